// File: rtl/pcie_tx_arbiter_if.sv
// Bundles the TLP source side and the PCIe core VC0 transmit side of the arbiter.
// master: arbiter view. slave: environment view (sources plus core).
interface pcie_tx_arbiter_if #(
    parameter int unsigned N = 3
);
    // Source side
    logic [N-1:0]    req_in;
    logic [2*N-1:0]  cls_in;
    logic [10*N-1:0] len_in;
    logic [N-1:0]    st_in;
    logic [N-1:0]    end_in;
    logic [16*N-1:0] data_in;
    logic [N-1:0]    gnt;

    // Core side
    logic            tx_req;
    logic            tx_rdy;
    logic            tx_st;
    logic            tx_end;
    logic [15:0]     tx_data;
    logic [8:0]      tx_ca_ph;
    logic [8:0]      tx_ca_nph;
    logic [8:0]      tx_ca_cplh;
    logic [12:0]     tx_ca_pd;
    logic [12:0]     tx_ca_npd;
    logic [12:0]     tx_ca_cpld;

    modport master (
        input  req_in, cls_in, len_in, st_in, end_in, data_in,
        input  tx_rdy, tx_ca_ph, tx_ca_nph, tx_ca_cplh, tx_ca_pd, tx_ca_npd, tx_ca_cpld,
        output gnt, tx_req, tx_st, tx_end, tx_data
    );

    modport slave (
        output req_in, cls_in, len_in, st_in, end_in, data_in,
        output tx_rdy, tx_ca_ph, tx_ca_nph, tx_ca_cplh, tx_ca_pd, tx_ca_npd, tx_ca_cpld,
        input  gnt, tx_req, tx_st, tx_end, tx_data
    );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// Round-robin, credit-gated arbiter sharing the PCIe core VC0 transmit port among N TLP
// sources. Arbitrates per whole TLP, runs the tx_req/tx_rdy handshake, then passes the
// owner's stream straight through to the core.
module pcie_tx_arbiter #(
    parameter int unsigned N           = 3,
    parameter int unsigned RDY_TIMEOUT = 1023
) (
    input  logic                     clk_125,
    input  logic                     sys_rst,
    pcie_tx_arbiter_if.master        bus,
    output logic                     busy,
    output logic [7:0]               timeout_cnt
);
    localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WaitW = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [7:0]        tocnt_q, tocnt_d;

    logic [N-1:0]      elig;
    logic              pick_vld;
    logic [IdxW-1:0]   pick_idx;
    logic [N-1:0]      gnt_vec;

    // Header field: MSB set means infinite, otherwise one header credit is needed.
    function automatic logic hdr_ok(input logic [8:0] avail);
        return avail[8] || (avail != 9'd0);
    endfunction

    // Data field: MSB set means infinite, otherwise unsigned compare against the need.
    function automatic logic data_ok(input logic [12:0] avail, input logic [8:0] need);
        return avail[12] || (avail >= {4'd0, need});
    endfunction

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        return (idx == IdxW'(N - 1)) ? '0 : idx + IdxW'(1);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_src
        logic [1:0]  cls;
        logic [9:0]  len;
        logic [10:0] len_p3;
        logic [8:0]  need_pd;
        logic [8:0]  need_np;
        logic        cred_ok;

        assign cls     = bus.cls_in[2*g +: 2];
        assign len     = bus.len_in[10*g +: 10];
        assign len_p3  = {1'b0, len} + 11'd3;
        assign need_pd = len_p3[10:2];
        assign need_np = {8'd0, |len};

        // Credit sufficiency for this source's class; reserved class is never granted.
        always_comb begin
            cred_ok = 1'b0;
            case (cls)
                2'b00:   cred_ok = hdr_ok(bus.tx_ca_ph)   && data_ok(bus.tx_ca_pd, need_pd);
                2'b01:   cred_ok = hdr_ok(bus.tx_ca_nph)  && data_ok(bus.tx_ca_npd, need_np);
                2'b10:   cred_ok = hdr_ok(bus.tx_ca_cplh) && data_ok(bus.tx_ca_cpld, need_pd);
                default: cred_ok = 1'b0;
            endcase
        end

        assign elig[g] = bus.req_in[g] & cred_ok;
    end

    // First eligible source at or after the rr pointer; scanning from the far end lets
    // the nearest offset win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (elig[IdxW'((int'(rr_q) + k) % int'(N))]) begin
                pick_vld = 1'b1;
                pick_idx = IdxW'((int'(rr_q) + k) % int'(N));
            end
        end
    end

    // Next-state logic: arbitration, core handshake with timeout, end-of-TLP release.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        wait_d  = wait_q;
        tocnt_d = tocnt_q;
        gnt_vec = '0;
        unique case (state_q)
            StIdle: begin
                wait_d = '0;
                if (pick_vld) begin
                    owner_d = pick_idx;
                    state_d = StReq;
                end
            end
            StReq: begin
                // tx_rdy takes precedence over a coincident timeout
                if (bus.tx_rdy) begin
                    gnt_vec[owner_q] = 1'b1;
                    state_d          = StXfer;
                end else if (wait_q == WaitW'(RDY_TIMEOUT - 1)) begin
                    state_d = StIdle;
                    rr_d    = next_idx(owner_q);
                    if (tocnt_q != 8'hff) begin
                        tocnt_d = tocnt_q + 8'd1;
                    end
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StXfer: begin
                if (bus.end_in[owner_q]) begin
                    rr_d    = next_idx(owner_q);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; a reset mid-TLP simply abandons it.
    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            rr_q    <= '0;
            wait_q  <= '0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            wait_q  <= wait_d;
            tocnt_q <= tocnt_d;
        end
    end

    // Zero-latency pass-through of the owner's stream while transferring.
    always_comb begin
        bus.tx_st   = 1'b0;
        bus.tx_end  = 1'b0;
        bus.tx_data = '0;
        if (state_q == StXfer) begin
            bus.tx_st   = bus.st_in[owner_q];
            bus.tx_end  = bus.end_in[owner_q];
            bus.tx_data = bus.data_in[{owner_q, 4'b0000} +: 16];
        end
    end

    assign bus.gnt     = gnt_vec;
    assign bus.tx_req  = (state_q == StReq);
    assign busy        = (state_q != StIdle);
    assign timeout_cnt = tocnt_q;
endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Self-checking bench for pcie_tx_arbiter: directed scenarios plus randomized rounds checked
// against a behavioural arbitration model.
module tb_pcie_tx_arbiter;
    localparam int unsigned N   = 3;
    localparam int unsigned TMO = 16;
    localparam int unsigned DW  = 16 * N;

    logic       clk_125 = 1'b0;
    logic       sys_rst;
    logic       busy;
    logic [7:0] timeout_cnt;

    pcie_tx_arbiter_if #(.N(N)) bus ();

    pcie_tx_arbiter #(.N(N), .RDY_TIMEOUT(TMO)) dut (
        .clk_125     (clk_125),
        .sys_rst     (sys_rst),
        .bus         (bus.master),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    always #4 clk_125 = ~clk_125;

    int checks = 0;
    int errors = 0;

    // Stimulus shadow and model state
    int s_req [N];
    int s_cls [N];
    int s_len [N];
    int c_ph, c_nph, c_cplh, c_pd, c_npd, c_cpld;
    int m_rr = 0;

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            bus.req_in[i]         = (s_req[i] != 0);
            bus.cls_in[2*i +: 2]  = 2'(s_cls[i]);
            bus.len_in[10*i +: 10] = 10'(s_len[i]);
        end
        bus.tx_ca_ph   = 9'(c_ph);
        bus.tx_ca_nph  = 9'(c_nph);
        bus.tx_ca_cplh = 9'(c_cplh);
        bus.tx_ca_pd   = 13'(c_pd);
        bus.tx_ca_npd  = 13'(c_npd);
        bus.tx_ca_cpld = 13'(c_cpld);
    endtask

    task automatic set_credits(input int h, input int d);
        c_ph = h; c_nph = h; c_cplh = h;
        c_pd = d; c_npd = d; c_cpld = d;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            s_req[i] = 0; s_cls[i] = 0; s_len[i] = 0;
        end
        bus.st_in   = '0;
        bus.end_in  = '0;
        bus.data_in = '0;
        bus.tx_rdy  = 1'b0;
        apply_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk_125);
        sys_rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk_125);
        sys_rst = 1'b0;
        m_rr = 0;
    endtask

    // Model: a source may go if it requests, its class is real, and the core has room.
    function automatic bit model_eligible(input int i);
        int need;
        if (s_req[i] == 0) return 1'b0;
        need = (s_len[i] + 3) / 4;
        case (s_cls[i])
            0: return (c_ph != 0) && (c_pd >= 4096 || c_pd >= need);
            1: return (c_nph != 0) && (c_npd >= 4096 || c_npd >= ((s_len[i] > 0) ? 1 : 0));
            2: return (c_cplh != 0) && (c_cpld >= 4096 || c_cpld >= need);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int i = (m_rr + k) % N;
            if (model_eligible(i)) return i;
        end
        return -1;
    endfunction

    // Drives one whole TLP from src through the handshake and stream, checking as it goes.
    // Entered and left in an IDLE cycle, just after a negedge.
    task automatic serve_tlp(input int src, input int rdy_delay, input int nwords,
                             input bit drop_req, output int lat);
        logic [N-1:0] exp_g;
        logic [15:0]  wd;
        lat = 0;
        #1;
        while (bus.tx_req !== 1'b1 && lat < 40) begin
            @(negedge clk_125); #1; lat++;
        end
        checks++;
        if (bus.tx_req !== 1'b1) begin
            errors++;
            $display("FAIL req_wait src=%0d: tx_req=%b after %0d cycles, want 1", src, bus.tx_req, lat);
            return;
        end
        for (int j = 0; j <= rdy_delay; j++) begin
            if (j > 0) begin @(negedge clk_125); #1; end
            if (bus.req_in[src] !== 1'b1)
                $display("WARN protocol: req_in[%0d] dropped before grant", src);
            bus.tx_rdy = (j == rdy_delay);
            exp_g = (j == rdy_delay) ? (N'(1) << src) : '0;
            #1;
            checks++;
            if (bus.tx_req !== 1'b1 || bus.gnt !== exp_g || busy !== 1'b1) begin
                errors++;
                $display("FAIL req_phase src=%0d cyc=%0d: tx_req=%b gnt=%b busy=%b, want 1 %b 1",
                         src, j, bus.tx_req, bus.gnt, busy, exp_g);
            end
        end
        for (int w = 0; w < nwords; w++) begin
            @(negedge clk_125); #1;
            bus.tx_rdy = 1'b0;
            if (w == 0 && drop_req) begin
                s_req[src] = 0;
                bus.req_in[src] = 1'b0;
            end
            // Non-owners babble; only the owner's stream may reach the core.
            bus.st_in   = N'($urandom);
            bus.end_in  = N'($urandom);
            bus.data_in = DW'({$urandom, $urandom});
            wd = 16'($urandom);
            bus.st_in[src]  = (w == 0);
            bus.end_in[src] = (w == nwords - 1);
            bus.data_in[16*src +: 16] = wd;
            #1;
            checks++;
            if (bus.tx_st !== (w == 0) || bus.tx_end !== (w == nwords - 1) || bus.tx_data !== wd ||
                bus.gnt !== '0 || bus.tx_req !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL xfer src=%0d word=%0d: st=%b end=%b data=%h gnt=%b req=%b busy=%b, want %b %b %h 0 0 1",
                         src, w, bus.tx_st, bus.tx_end, bus.tx_data, bus.gnt, bus.tx_req, busy,
                         (w == 0), (w == nwords - 1), wd);
            end
        end
        @(negedge clk_125); #1;
        bus.st_in  = '0;
        bus.end_in = '0;
        m_rr = (src + 1) % N;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.tx_st !== 1'b0 || bus.tx_req !== 1'b0) begin
            errors++;
            $display("FAIL after_end src=%0d: busy=%b tx_st=%b tx_req=%b, want 0 0 0",
                     src, busy, bus.tx_st, bus.tx_req);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        clear_inputs();
        set_credits(8, 64);
        s_req[0] = 1;
        apply_inputs();
        repeat (3) @(negedge clk_125);
        #1;
        checks++;
        if ({busy, bus.tx_req, bus.tx_st, bus.tx_end} !== 4'b0 || bus.gnt !== '0 ||
            bus.tx_data !== 16'h0 || timeout_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b req=%b st=%b end=%b gnt=%b data=%h tocnt=%0d, want all 0",
                     busy, bus.tx_req, bus.tx_st, bus.tx_end, bus.gnt, bus.tx_data, timeout_cnt);
        end
        clear_inputs();
        sys_rst = 1'b0;
        m_rr = 0;
        @(negedge clk_125); #1;
        checks++;
        if (busy !== 1'b0 || bus.tx_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b tx_req=%b, want 0 0", busy, bus.tx_req);
        end
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        set_credits(8, 64);
        s_req[0] = 1; s_cls[0] = 0; s_len[0] = 4;
        apply_inputs();
        serve_tlp(0, 2, 8, 1'b1, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL single_latency: req_in->tx_req took %0d cycles, want 1", lat);
        end
    endtask

    task automatic test_round_robin();
        int lat;
        do_reset();
        set_credits(8, 64);
        for (int i = 0; i < N; i++) begin
            s_req[i] = 1; s_cls[i] = 0; s_len[i] = 0;
        end
        apply_inputs();
        for (int k = 0; k < 6; k++) begin
            serve_tlp(k % N, 0, 1, 1'b0, lat);
            checks++;
            if (lat < 1) begin
                errors++;
                $display("FAIL rr_gap k=%0d: idle cycles=%0d, want >=1", k, lat);
            end
        end
        clear_inputs();
    endtask

    task automatic test_credit_skip();
        int lat;
        clear_inputs();
        set_credits(8, 8);
        c_cpld = 1;
        s_req[0] = 1; s_cls[0] = 2; s_len[0] = 8;
        s_req[1] = 1; s_cls[1] = 0; s_len[1] = 2;
        apply_inputs();
        serve_tlp(1, 1, 4, 1'b1, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_125); #1;
            checks++;
            if (bus.tx_req !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cpl_withheld cyc=%0d: tx_req=%b busy=%b, want 0 0", c, bus.tx_req, busy);
            end
        end
        c_cpld = 2;
        apply_inputs();
        serve_tlp(0, 0, 16, 1'b1, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL cpl_release_latency: %0d cycles, want 1", lat);
        end
    endtask

    task automatic test_credit_bounds();
        int lat;
        clear_inputs();
        set_credits(8, 64);
        c_pd = 13'h1000;
        s_req[2] = 1; s_cls[2] = 0; s_len[2] = 1023;
        apply_inputs();
        serve_tlp(2, 0, 4, 1'b1, lat);
        c_pd = 255;
        s_req[2] = 1;
        apply_inputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_125); #1;
            checks++;
            if (bus.tx_req !== 1'b0) begin
                errors++;
                $display("FAIL pd255_withheld cyc=%0d: tx_req=%b, want 0", c, bus.tx_req);
            end
        end
        c_pd = 256;
        apply_inputs();
        serve_tlp(2, 0, 2, 1'b1, lat);
    endtask

    task automatic test_timeout();
        int g;
        int cnt;
        int lat;
        do_reset();
        set_credits(8, 64);
        s_req[0] = 1; s_req[1] = 1;
        apply_inputs();
        g = 0;
        #1;
        while (bus.tx_req !== 1'b1 && g < 10) begin
            @(negedge clk_125); #1; g++;
        end
        cnt = 0;
        while (bus.tx_req === 1'b1 && cnt < 4 * TMO) begin
            cnt++;
            @(negedge clk_125); #1;
        end
        checks++;
        if (cnt != TMO) begin
            errors++;
            $display("FAIL timeout_len: tx_req high %0d cycles, want %0d", cnt, TMO);
        end
        checks++;
        if (timeout_cnt !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cnt: cnt=%0d busy=%b, want 1 0", timeout_cnt, busy);
        end
        m_rr = 1;
        serve_tlp(1, 0, 1, 1'b1, lat);
        serve_tlp(0, 0, 1, 1'b1, lat);
    endtask

    task automatic test_reset_mid_xfer();
        int g;
        int lat;
        logic [15:0] wd;
        clear_inputs();
        set_credits(8, 64);
        s_req[1] = 1;
        apply_inputs();
        serve_tlp(1, 0, 1, 1'b1, lat);
        s_req[2] = 1; s_len[2] = 4;
        apply_inputs();
        g = 0;
        #1;
        while (bus.tx_req !== 1'b1 && g < 10) begin
            @(negedge clk_125); #1; g++;
        end
        bus.tx_rdy = 1'b1;
        #1;
        checks++;
        if (bus.gnt !== N'(4)) begin
            errors++;
            $display("FAIL rst_mid_gnt: gnt=%b, want 100", bus.gnt);
        end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk_125); #1;
            bus.tx_rdy = 1'b0;
            wd = 16'($urandom) | 16'h0001;
            bus.st_in = (w == 0) ? N'(4) : N'(0);
            bus.data_in[32 +: 16] = wd;
            if (w == 2) sys_rst = 1'b1;
            #1;
            checks++;
            if (bus.tx_st !== (w == 0) || bus.tx_data !== wd) begin
                errors++;
                $display("FAIL rst_mid_word w=%0d: st=%b data=%h, want %b %h", w, bus.tx_st, bus.tx_data,
                         (w == 0), wd);
            end
        end
        @(negedge clk_125); #1;
        sys_rst = 1'b0;
        #1;
        checks++;
        if ({busy, bus.tx_req, bus.tx_st, bus.tx_end} !== 4'b0 || bus.gnt !== '0 ||
            bus.tx_data !== 16'h0 || timeout_cnt !== 8'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: busy=%b req=%b st=%b end=%b gnt=%b data=%h tocnt=%0d, want all 0",
                     busy, bus.tx_req, bus.tx_st, bus.tx_end, bus.gnt, bus.tx_data, timeout_cnt);
        end
        bus.st_in   = '0;
        bus.data_in = '0;
        m_rr = 0;
        s_req[1] = 1;
        apply_inputs();
        // rr back at 0, so source 1 precedes source 2
        serve_tlp(1, 1, 2, 1'b1, lat);
        serve_tlp(2, 0, 8, 1'b1, lat);
    endtask

    function automatic int rand_hdr();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return $urandom_range(1, 3);
            2:       return 256 + $urandom_range(0, 255);
            default: return $urandom_range(0, 8);
        endcase
    endfunction

    function automatic int rand_data();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return $urandom_range(1, 4);
            2:       return 4096 + $urandom_range(0, 4095);
            3:       return $urandom_range(250, 260);
            default: return $urandom_range(0, 300);
        endcase
    endfunction

    task automatic test_random();
        int p;
        int lat;
        clear_inputs();
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                s_req[i] = $urandom_range(0, 1);
                s_cls[i] = $urandom_range(0, 3);
                s_len[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 12);
            end
            c_ph = rand_hdr(); c_nph = rand_hdr(); c_cplh = rand_hdr();
            c_pd = rand_data(); c_npd = rand_data(); c_cpld = rand_data();
            apply_inputs();
            p = model_pick();
            if (p < 0) begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk_125); #1;
                    checks++;
                    if (bus.tx_req !== 1'b0 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_idle r=%0d cyc=%0d: tx_req=%b busy=%b, want 0 0",
                                 r, c, bus.tx_req, busy);
                    end
                end
            end else begin
                serve_tlp(p, $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)), lat);
                checks++;
                if (lat != 1) begin
                    errors++;
                    $display("FAIL rand_latency r=%0d src=%0d: %0d cycles, want 1", r, p, lat);
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_credit_skip();
        test_credit_bounds();
        test_timeout();
        test_reset_mid_xfer();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
